// File: rtl/regfile_mp.sv
// Multi-port GPR file with an integrated busy scoreboard; x0 reads as zero and is never busy.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_val_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_val_i,
    input  logic                     iss_en_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic                     any_busy_o
);

    logic [DATA_W-1:0]   gpr [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [ADDR_W-1:0]   ra;
    logic [ADDR_W-1:0]   wa;

    // Later non-blocking assignments win: highest write port beats lower ones,
    // and an issue set beats a writeback clear on the same register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpr  <= '{default: '0};
            busy <= '0;
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] != '0)) begin
                    gpr[wr_addr_i[j*ADDR_W +: ADDR_W]]  <= wr_val_i[j*DATA_W +: DATA_W];
                    busy[wr_addr_i[j*ADDR_W +: ADDR_W]] <= 1'b0;
                end
            end
            if (iss_en_i && (iss_addr_i != '0)) begin
                busy[iss_addr_i] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_val_o  = '0;
        rd_busy_o = '0;
        ra        = '0;
        wa        = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = rd_addr_i[k*ADDR_W +: ADDR_W];
            rd_val_o[k*DATA_W +: DATA_W] = gpr[ra];
            rd_busy_o[k]                 = busy[ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                wa = wr_addr_i[j*ADDR_W +: ADDR_W];
                if (wr_en_i[j] && (wa == ra) && (ra != '0)) begin
                    rd_val_o[k*DATA_W +: DATA_W] = wr_val_i[j*DATA_W +: DATA_W];
                    rd_busy_o[k]                 = 1'b0;
                end
            end
`endif
        end
    end

    assign any_busy_o = |busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (two read ports, two write ports).
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_val;
    logic [1:0]      rd_busy;
    logic [1:0]      wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_val;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            any_busy;

    int checks   = 0;
    int failures = 0;

    regfile_mp #(
        .DATA_W  (DW),
        .NUM_REGS(32),
        .ADDR_W  (AW),
        .NUM_RD  (2),
        .NUM_WR  (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .rd_addr_i (rd_addr),
        .rd_val_o  (rd_val),
        .rd_busy_o (rd_busy),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_val_i  (wr_val),
        .iss_en_i  (iss_en),
        .iss_addr_i(iss_addr),
        .any_busy_o(any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] v);
        wr_en[p]            = en;
        wr_addr[p*AW +: AW] = a;
        wr_val[p*DW +: DW]  = v;
    endtask

    task automatic clr_in();
        wr_en    = '0;
        wr_addr  = '0;
        wr_val   = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    function automatic logic [DW-1:0] rv(input int p);
        return rd_val[p*DW +: DW];
    endfunction

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        clr_in();
        #1;
        check("reset_val", 64'(rv(0)), 64'h0);
        check("reset_busy", 64'(rd_busy), 64'h0);
        check("reset_any", 64'(any_busy), 64'h0);
        step();
        rst_n = 1'b1;
        step();

        // write x5 and issue x6, then reset asynchronously mid-cycle
        set_wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
        iss_en = 1'b1; iss_addr = 5'd6;
        step();
        clr_in();
        set_rd(0, 5'd5);
        set_rd(1, 5'd6);
        #1;
        check("x5_written", 64'(rv(0)), 64'hDEADBEEF);
        check("x6_busy", 64'(rd_busy), 64'h2);
        check("any_busy_set", 64'(any_busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("async_rst_val", 64'(rv(0)), 64'h0);
        check("async_rst_any", 64'(any_busy), 64'h0);
        check("async_rst_busy", 64'(rd_busy), 64'h0);
        set_wr(0, 1'b1, 5'd5, 32'h0BAD0BAD);
        step();
        rst_n = 1'b1;
        clr_in();
        #1;
        check("rst_discards_wr", 64'(rv(0)), 64'h0);

        // x0 protection
        set_wr(1, 1'b1, 5'd0, 32'h12345678);
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        clr_in();
        set_rd(0, 5'd0);
        #1;
        check("x0_val", 64'(rv(0)), 64'h0);
        check("x0_busy", 64'(rd_busy[0]), 64'h0);
        check("x0_any", 64'(any_busy), 64'h0);

        // write port collision
        set_wr(0, 1'b1, 5'd7, 32'h11);
        set_wr(1, 1'b1, 5'd7, 32'h22);
        step();
        clr_in();
        set_rd(0, 5'd7);
        #1;
        check("collision_x7", 64'(rv(0)), 64'h22);

        // scoreboard on x3
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        clr_in();
        set_rd(1, 5'd3);
        #1;
        check("x3_busy_c1", 64'(rd_busy[1]), 64'h1);
        check("any_busy_c1", 64'(any_busy), 64'h1);
        step(); step(); step();
        check("x3_busy_c4", 64'(rd_busy[1]), 64'h1);
        set_wr(0, 1'b1, 5'd3, 32'h55);
        #1;
        check("x3_pre_val", 64'(rv(1)), BYP ? 64'h55 : 64'h0);
        check("x3_pre_busy", 64'(rd_busy[1]), BYP ? 64'h0 : 64'h1);
        step();
        clr_in();
        #1;
        check("x3_c5_val", 64'(rv(1)), 64'h55);
        check("x3_c5_busy", 64'(rd_busy[1]), 64'h0);
        check("any_busy_c5", 64'(any_busy), 64'h0);
        set_wr(1, 1'b1, 5'd3, 32'h66);
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        clr_in();
        #1;
        check("set_wins_busy", 64'(rd_busy[1]), 64'h1);
        check("set_wins_val", 64'(rv(1)), 64'h66);
        iss_en = 1'b1; iss_addr = 5'd3;
        step();
        clr_in();
        set_wr(0, 1'b1, 5'd3, 32'h77);
        step();
        clr_in();
        #1;
        check("no_count_busy", 64'(rd_busy[1]), 64'h0);

        // read during write on x9
        set_wr(0, 1'b1, 5'd9, 32'h1);
        iss_en = 1'b1; iss_addr = 5'd9;
        step();
        clr_in();
        set_rd(0, 5'd9);
        set_wr(1, 1'b1, 5'd9, 32'hA5A5);
        #1;
        check("rdw_val", 64'(rv(0)), BYP ? 64'hA5A5 : 64'h1);
        check("rdw_busy", 64'(rd_busy[0]), BYP ? 64'h0 : 64'h1);
        step();
        clr_in();
        #1;
        check("rdw_after_val", 64'(rv(0)), 64'hA5A5);
        check("rdw_after_busy", 64'(rd_busy[0]), 64'h0);

        // back-to-back writes to x1
        set_rd(0, 5'd1);
        for (int i = 1; i <= 3; i++) begin
            set_wr(0, 1'b1, 5'd1, 32'(i));
            #1;
            check($sformatf("b2b_%0d", i), 64'(rv(0)), BYP ? 64'(i) : 64'(i - 1));
            step();
        end
        clr_in();
        #1;
        check("b2b_final", 64'(rv(0)), 64'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Clocked, multi-port general-purpose register file for the pipelined core.
- Parametrised number of read and write ports, register width and register count.
- Integrated busy scoreboard: ID marks a destination busy at issue; WB clears it at writeback.
- Read ports serve ID operand fetch; write ports serve WB; x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- ADDR_W, $clog2(NUM_REGS), register address width.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports.

Ports:
- clk_i  in  1  core clock; all state updates on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- rd_val_o  out  NUM_RD*DATA_W  read data per port.
- rd_busy_o  out  NUM_RD  scoreboard busy bit of each read address.
- wr_en_i  in  NUM_WR  write enable per write port.
- wr_addr_i  in  NUM_WR*ADDR_W  write addresses.
- wr_val_i  in  NUM_WR*DATA_W  write data.
- iss_en_i  in  1  issue strobe: mark iss_addr_i busy.
- iss_addr_i  in  ADDR_W  destination register being issued.
- any_busy_o  out  1  OR of all scoreboard bits; drains the pipeline before a CSR/fence.

Behaviour:
- Reset, asynchronous, on rst_ni low:
  - All registers clear to 0.
  - All busy bits clear to 0.
  - Therefore rd_val_o = 0, rd_busy_o = 0 and any_busy_o = 0 while reset is asserted and immediately after it.
  - Reset asserted mid-write discards that write.
- Reads are combinational, zero latency: rd_val_o[k] = GPR[rd_addr_i[k]].
  - Address 0 always reads 0 and never busy.
  - Addresses >= NUM_REGS (non-power-of-two use forbidden) are not supported.
- Writes take effect on the rising clk_i edge when wr_en_i[j] = 1 and wr_addr_i[j] != 0.
  - Writes to address 0 are dropped.
  - Write-port collision on the same address in the same cycle: the highest-index port wins, both for data and for busy clear.
- Scoreboard, updated on the clk_i edge:
  - A write to address a clears busy[a].
  - iss_en_i with iss_addr_i = a != 0 sets busy[a].
  - Same address set and cleared in the same cycle: set wins (a newer producer is outstanding).
  - iss_addr_i = 0 is ignored.
  - Issuing to an already-busy address keeps it busy (no counting; one outstanding producer per register).
- any_busy_o is combinational from the busy bits; it updates one cycle after set or clear.
- Read during write, same address, same cycle: governed by REGFILE_BYPASS_EN.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined:
  - Read ports forward same-cycle write data combinationally.
  - If any wr_en_i[j] targets rd_addr_i[k] != 0, rd_val_o[k] = wr_val_i of the highest such j.
  - rd_busy_o[k] = 0 for that cycle (the value is being delivered).
- Undefined:
  - Reads return the pre-edge register contents.
  - rd_busy_o[k] shows the stored busy bit.
  - The new value and cleared busy bit are visible the cycle after the edge.

Test Plan:
- Reset: assert rst_ni = 0 after writing 0xDEADBEEF to x5 -> rd_val_o for x5 = 0 immediately (asynchronously); any_busy_o = 0.
- x0 protection: write 0x12345678 to x0 -> a read of x0 returns 0 the next cycle; issuing to x0 leaves rd_busy_o = 0.
- Write collision (NUM_WR = 2): both ports write x7, port0 = 0x11, port1 = 0x22 -> x7 reads 0x22.
- Scoreboard:
  - Issue x3 at cycle 0 -> rd_busy_o for x3 = 1 at cycle 1, any_busy_o = 1.
  - Write x3 = 0x55 at cycle 4 -> busy = 0 and value 0x55 at cycle 5.
  - Write x3 together with a new issue of x3 in the same cycle -> busy stays 1.
- Read-during-write: write x9 = 0xA5A5 while reading x9 (previously 0x1).
  - With REGFILE_BYPASS_EN -> 0xA5A5 same cycle.
  - Without it -> 0x1, then 0xA5A5 the next cycle.
- Back-to-back writes: x1 = 1, 2, 3 on consecutive cycles, read each cycle -> 1, 2, 3 seen with one-cycle lag (bypass off).
